// File: rtl/zx_pager.sv
// zx_pager: ZX Spectrum memory pager and system-port controller.
//
// Turns Z80 bus cycles into physical ROM/RAM addresses for 128K, Pentagon 512K
// or 1024K memory layouts. It owns the paging ports 7FFD and 1FFD and the ULA
// port FE, and it generates the /INT pulse from the video vblank edge.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   cpu_a, cpu_do         Z80 address bus and write data
//   n_mreq..n_m1          Z80 control strobes (active-low)
//   vblank                video vertical blank (active-high)
//   rom_cs, rom_addr      ROM select and physical ROM address (combinational)
//   ram_addr              physical RAM address (combinational)
//   ram_we/wdata/waddr    registered one-clock RAM write pulse with its data
//   vid_shadow            screen bank select (0 = bank 5, 1 = bank 7)
//   border, speaker       FE port state
//   paging_locked         7FFD.D5 lock bit (never set in the 1024K layout)
//   n_int                 Z80 /INT (active-low)
module zx_pager #(
  parameter int RAM_BANKS_LOG2 = 3,
  parameter int ROM_PAGES_LOG2 = 1,
  parameter int EXT_PORT_EN    = 0,
  parameter int INT_LEN        = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [15:0]                 cpu_a,
  input  logic [7:0]                  cpu_do,
  input  logic                        n_mreq,
  input  logic                        n_iorq,
  input  logic                        n_rd,
  input  logic                        n_wr,
  input  logic                        n_m1,
  input  logic                        vblank,
  output logic                        rom_cs,
  output logic [14+ROM_PAGES_LOG2-1:0] rom_addr,
  output logic [14+RAM_BANKS_LOG2-1:0] ram_addr,
  output logic                        ram_we,
  output logic [7:0]                  ram_wdata,
  output logic [14+RAM_BANKS_LOG2-1:0] ram_waddr,
  output logic                        vid_shadow,
  output logic [2:0]                  border,
  output logic                        speaker,
  output logic                        paging_locked,
  output logic                        n_int
);

  localparam int RAM_AW = 14 + RAM_BANKS_LOG2;
  localparam int ROM_AW = 14 + ROM_PAGES_LOG2;
  // In the 1024K layout D5 of 7FFD is a bank bit, so the lock is disabled.
  localparam bit LOCK_EN = (RAM_BANKS_LOG2 != 6);
  localparam bit EXT_EN  = (EXT_PORT_EN != 0);
  localparam logic [7:0] INT_LOAD = 8'(INT_LEN);

  logic [7:0]        r_p7ffd;
  logic              r_p1ffd2;
  logic [2:0]        r_border;
  logic              r_speaker;
  logic [7:0]        r_intCnt;
  logic              r_ioWrQ;
  logic              r_memWrQ;
  logic              r_vblankQ;
  logic              r_ramWe;
  logic [RAM_AW-1:0] r_ramWaddr;
  logic [7:0]        r_ramWdata;

  logic              w_ioWr;
  logic              w_memWr;
  logic              w_ioEvent;
  logic              w_memEvent;
  logic              w_sel1ffd;
  logic              w_sel7ffd;
  logic              w_selFe;
  logic              w_locked;
  logic [5:0]        w_bankSel;
  logic [5:0]        w_bank;
  logic [1:0]        w_romPage;
  logic [RAM_AW-1:0] w_ramAddr;
  logic              w_unused;

  // Reads need no decoding here; n_rd is part of the bus bundle only.
  assign w_unused = n_rd;

  // Bus-cycle qualifiers. Events fire only on the first cycle of a strobe, so a
  // write held low for many clocks commits exactly once.
  assign w_ioWr     = !n_iorq && !n_wr && n_m1;
  assign w_memWr    = !n_mreq && !n_wr;
  assign w_ioEvent  = w_ioWr && !r_ioWrQ;
  assign w_memEvent = w_memWr && !r_memWrQ && (cpu_a[15:14] != 2'b00);

  // Partial port decode; 1FFD has priority because it also matches 7FFD.
  assign w_sel1ffd = EXT_EN && (cpu_a[15:12] == 4'b0001) && !cpu_a[1];
  assign w_sel7ffd = !w_sel1ffd && !cpu_a[15] && !cpu_a[1];
  assign w_selFe   = !w_sel1ffd && !w_sel7ffd && !cpu_a[0];
  assign w_locked  = LOCK_EN && r_p7ffd[5];

  // Full 6-bit bank; the address cast below keeps only the layout's low bits.
  assign w_bankSel = {r_p7ffd[5], r_p7ffd[7:6], r_p7ffd[2:0]};

  always_comb begin
    w_bank = 6'd0;
    case (cpu_a[15:14])
      2'b01:   w_bank = 6'd5;
      2'b10:   w_bank = 6'd2;
      2'b11:   w_bank = w_bankSel;
      default: w_bank = 6'd0;
    endcase
  end

  assign w_ramAddr = RAM_AW'({w_bank, cpu_a[13:0]});
  assign w_romPage = {r_p1ffd2, r_p7ffd[4]};

  assign rom_cs        = (cpu_a[15:14] == 2'b00);
  assign rom_addr      = ROM_AW'({w_romPage, cpu_a[13:0]});
  assign ram_addr      = w_ramAddr;
  assign ram_we        = r_ramWe;
  assign ram_wdata     = r_ramWdata;
  assign ram_waddr     = r_ramWaddr;
  assign vid_shadow    = r_p7ffd[3];
  assign border        = r_border;
  assign speaker       = r_speaker;
  assign paging_locked = w_locked;
  assign n_int         = (r_intCnt == 8'd0);

  // Port registers. The previous-cycle flags reset high so a bus cycle still
  // in flight when reset drops is treated as already seen.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_p7ffd   <= 8'd0;
      r_p1ffd2  <= 1'b0;
      r_border  <= 3'd0;
      r_speaker <= 1'b0;
      r_ioWrQ   <= 1'b1;
    end else begin
      r_ioWrQ <= w_ioWr;
      if (w_ioEvent) begin
        if (w_sel1ffd) begin
          if (!w_locked) r_p1ffd2 <= cpu_do[2];
        end else if (w_sel7ffd) begin
          if (!w_locked) r_p7ffd <= cpu_do;
        end else if (w_selFe) begin
          r_border  <= cpu_do[2:0];
          r_speaker <= cpu_do[4] ^ cpu_do[3];
        end
      end
    end
  end

  // RAM write path: capture address and data on the event, pulse for one clock.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_memWrQ   <= 1'b1;
      r_ramWe    <= 1'b0;
      r_ramWaddr <= '0;
      r_ramWdata <= 8'd0;
    end else begin
      r_memWrQ <= w_memWr;
      r_ramWe  <= w_memEvent;
      if (w_memEvent) begin
        r_ramWaddr <= w_ramAddr;
        r_ramWdata <= cpu_do;
      end
    end
  end

  // /INT generator: a vblank rise loads the counter only when it is idle, so
  // edges during an active pulse do not stretch it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vblankQ <= 1'b0;
      r_intCnt  <= 8'd0;
    end else begin
      r_vblankQ <= vblank;
      if (vblank && !r_vblankQ && (r_intCnt == 8'd0)) begin
        r_intCnt <= INT_LOAD;
      end else if (r_intCnt != 8'd0) begin
        r_intCnt <= r_intCnt - 8'd1;
      end
    end
  end

endmodule

// File: doc/zx_pager.md
# zx_pager

Parametrised ZX Spectrum memory pager and system-port controller for the a-z80 top level. It decodes Z80 bus cycles into ROM/RAM physical addresses for 128K, Pentagon 512K or 1024K configurations, and it owns ports 7FFD, 1FFD and FE. Port and RAM writes are committed as single-cycle, edge-detected events rather than level-sensitive strobes. It also generates a fixed-width /INT pulse from the video vblank edge, and it sits between z80_top_direct_n, the RAM/ROM macros and the video unit.

## Interface
- RAM_BANKS_LOG2, 3: log2 of the number of 16K RAM banks; legal values are 3 (128K), 5 (512K) and 6 (1024K).
- ROM_PAGES_LOG2, 1: log2 of the number of 16K ROM pages; legal values are 1 and 2.
- EXT_PORT_EN, 0: set to 1 to decode port 1FFD.
- INT_LEN, 32: width of the /INT pulse, in clock cycles (1..255).
- clock  in  1  System clock. All CPU bus inputs are synchronous to it.
- reset  in  1  Synchronous reset, active-high.
- cpu_a  in  16  Z80 address bus.
- cpu_do  in  8  Z80 write data.
- n_mreq, n_iorq, n_rd, n_wr, n_m1  in  1 each  Z80 control signals, active-low.
- vblank  in  1  Video vertical blank, active-high.
- rom_cs  out  1  The current address decodes to ROM (cpu_a[15:14]=00).
- rom_addr  out  14+ROM_PAGES_LOG2  Physical ROM address.
- ram_addr  out  14+RAM_BANKS_LOG2  Physical RAM address.
- ram_we  out  1  RAM write pulse, one clock wide.
- ram_wdata  out  8  Write data, registered and aligned with ram_we.
- ram_waddr  out  14+RAM_BANKS_LOG2  Write address, registered and aligned with ram_we.
- vid_shadow  out  1  Screen select: 0 selects bank 5, 1 selects bank 7.
- border  out  3  Border colour.
- speaker  out  1  Beeper output, equal to FE.D4 xor FE.D3.
- paging_locked  out  1  Value of 7FFD.D5 (always 0 when RAM_BANKS_LOG2=6).
- n_int  out  1  Z80 /INT, active-low.

## Operation
- Registers: p7ffd[7:0], p1ffd[2] (exists only when EXT_PORT_EN=1), border, speaker, int counter, and the previous-cycle flags io_wr_q and mem_wr_q.
- Port write event: n_iorq=0, n_wr=0, n_m1=1 in the current cycle with io_wr_q=0 in the previous cycle. Exactly one event is produced per I/O cycle.
- Port decode, partial:
  - 7FFD: cpu_a[15]=0 and cpu_a[1]=0.
  - 1FFD: cpu_a[15:12]=0001 and cpu_a[1]=0; checked before 7FFD.
  - FE: cpu_a[0]=0 and the address is neither 7FFD nor 1FFD.
  - FFFD and BFFD are ignored.
- 7FFD and 1FFD writes are dropped while paging_locked=1. When RAM_BANKS_LOG2=6, D5 is a bank bit and the lock never engages.
- RAM bank number: {p7ffd[5], p7ffd[7:6], p7ffd[2:0]}, truncated to RAM_BANKS_LOG2 bits (bits 2:0 for 128K, 4:0 for 512K, 5:0 for 1024K).
- Address map, combinational from cpu_a and the registers:
  - 0000-3FFF: ROM page {p1ffd[2], p7ffd[4]} truncated to ROM_PAGES_LOG2. When ROM_PAGES_LOG2=1 the page is p7ffd[4].
  - 4000-7FFF: RAM bank 5.
  - 8000-BFFF: RAM bank 2.
  - C000-FFFF: the selected RAM bank.
- vid_shadow = p7ffd[3].
- FE write: border <= D[2:0], speaker <= D[4]^D[3].
- RAM write event: n_mreq=0, n_wr=0, cpu_a[15:14]!=00, with mem_wr_q=0 in the previous cycle. The event latches ram_waddr and ram_wdata and pulses ram_we for the following cycle. Writes to ROM space produce no pulse.
- Interrupt:
  - A rising edge of vblank loads the counter with INT_LEN; n_int=0 while the counter is nonzero.
  - A vblank edge that arrives while the counter is nonzero is ignored (no retrigger).

## Timing
- Reset values:
  - p7ffd=0, p1ffd=0, border=0, speaker=0, ram_we=0, n_int=1, counter=0.
  - io_wr_q=1 and mem_wr_q=1, so a bus cycle that is in flight when reset deasserts is never committed.
- rom_addr, ram_addr and rom_cs have zero latency; they reflect a register update in the cycle after the write event.
- Port register update: 1 cycle after the event cycle.
- ram_we: asserted exactly 1 cycle after the event cycle, for exactly 1 cycle, even if n_wr is held low for many cycles.
- n_int: falls 1 cycle after the vblank rise and stays low for exactly INT_LEN cycles.
- Reset asserted mid-pulse: n_int returns to 1 in the next cycle.
- If reset and a write event coincide, reset wins.

## Test plan
- Default parameters: OUT (7FFD),0x13 then read C000 → ram_addr=0x0C000 (bank 3), rom_addr=0x4000 (page 1); n_wr held low for 10 cycles → exactly one register update.
- OUT 7FFD,0x20 then OUT 7FFD,0x07 → paging_locked=1, bank stays 0; after a reset pulse, OUT 7FFD,0x07 → bank 7.
- RAM_BANKS_LOG2=5: OUT 7FFD,0xC5 → bank 0x1D, ram_addr for C123 = 0x74123. RAM_BANKS_LOG2=6: OUT 7FFD,0x20 → bank 0x20 and paging_locked=0.
- EXT_PORT_EN=1, ROM_PAGES_LOG2=2: OUT 1FFD,0x04 and OUT 7FFD,0x10 → ROM page 3, rom_addr for 0x0100 = 0xC100.
- Memory write to 0x4000 with data 0xAA, n_wr low for 3 cycles → a single ram_we pulse with ram_waddr=0x14000 and ram_wdata=0xAA. A write to 0x1000 → no ram_we.
- OUT FE,0x15 → border=5, speaker=1. Rising edge of vblank → n_int low for exactly 32 cycles; a second edge at cycle 10 is ignored.
